dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Sequencing front-end for the byte-addressed, big-endian word data memory. It shares that memory between two requesters: port 0 (CPU load/store) and port 1 (debug/DMA loader). Arbitration is round-robin, and each transaction uses a req/done handshake. The block drives the memory's `memRead`/`memWrite` strobes for a fixed, parameterised number of cycles. It also rejects word accesses whose four bytes would run past the end of memory.

## Interface
Parameters:
- `ADDR_W`, 6: memory byte-address width; memory depth is 2**ADDR_W bytes.
- `DATA_W`, 32: word width; fixed at 4 bytes.
- `RD_LAT`, 1: cycles `memRead` is held before `memDataOut` is sampled; legal range 1–4.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0` / `req1`  in  1  transaction request, port 0 / port 1.
- `we0` / `we1`  in  1  1 = write, 0 = read; must be stable while req is high.
- `addr0` / `addr1`  in  ADDR_W  byte address of the MSB byte.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `done0` / `done1`  out  1  one-cycle completion pulse.
- `err0` / `err1`  out  1  range error; valid only with done.
- `rdata0` / `rdata1`  out  DATA_W  read data; valid with done and held until the next read completes on that port.
- `memAddr`  out  ADDR_W  address to the memory.
- `memDataIn`  out  DATA_W  write data to the memory.
- `memRead`, `memWrite`  out  1  memory strobes; never both high.
- `memDataOut`  in  DATA_W  read data from the memory.
- `busy`  out  1  high in any state other than IDLE.

## Operation
States: IDLE, RD, WR, DONE.

IDLE
- `req0`/`req1` are sampled only in this state.
- If exactly one req is high, that port wins.
- If both are high, the port not served last wins.
- `lastId` resets to 1, so port 0 wins the first tie.
- On a grant, latch id, `we`, `addr` and `wdata`, and update `lastId`.
- Range check: an address greater than 2**ADDR_W−4 (greater than 60 by default) is an error. The next state is DONE with err set, and no memory strobe is issued.
- A valid write goes to WR; a valid read goes to RD and loads the latency counter with RD_LAT−1.

WR
- `memWrite` = 1 for exactly one cycle.
- `memAddr` / `memDataIn` come from the latched values.
- Next state is DONE.

RD
- `memRead` = 1 while in this state; the counter decrements each cycle.
- When the counter reaches 0, capture `memDataOut` into the winner's `rdata` register and go to DONE.

DONE
- Pulse the winner's done for one cycle.
- err = 1 for an error transaction, otherwise 0.
- The non-winner's done and err stay 0.
- Next state is always IDLE.

Handshake
- The requester keeps req and its fields stable until it sees done.
- It deasserts req in the cycle after done unless it is issuing a new transaction with new fields.
- A req held high through DONE is treated as a new request in the following IDLE cycle.

Output registers
- `memAddr` / `memDataIn` are registered and hold their last value outside WR/RD.
- `memRead`, `memWrite` and `busy` are decoded from the state register only.
- Err transactions leave `rdata` unchanged.

Reset
- Any state returns to IDLE asynchronously.
- All outputs go to 0: done, err, rdata, `memAddr`, `memDataIn`, `memRead`, `memWrite`, `busy`. `lastId` goes to 1.
- A transaction aborted by reset never produces done, and the requester must reissue it.

## Timing
Let req be sampled high in IDLE at edge E0.
- Write: `memWrite` is high during cycle E0→E1; done is high during E1→E2.
- Read: `memRead` is high for RD_LAT cycles from E0; `memDataOut` is sampled at edge E0+RD_LAT; done and `rdata` are valid in the following cycle.
- Error: done and err are high during cycle E0→E1.
- Minimum spacing between grants: write 3 cycles, read RD_LAT+2 cycles, error 2 cycles. Every transaction includes one IDLE cycle.
- No combinational path from req/addr to any memory output.

## Test plan
- Port 0 writes `addr0`=8, `wdata0`=0xDEADBEEF → `memWrite` is high exactly one cycle with `memAddr`=8 and `memDataIn`=0xDEADBEEF; `done0` follows in the next cycle; `err0`=0.
- Port 1 reads `addr1`=8 with RD_LAT=1 against the memory model → `rdata1`=0xDEADBEEF with `done1` 2 cycles after the sample; `done0` stays 0.
- Both ports request a read at the same time, four consecutive times, right after reset → grant order is 0, 1, 0, 1; each done lands on the correct port.
- Port 0 reads `addr0`=61 → `done0`=1, `err0`=1, one cycle after the sample, with no `memRead`. `addr0`=60 → normal read, `err0`=0.
- RD_LAT=3, read of `addr0`=4 → `memRead` is high 3 cycles and `done0` arrives 4 cycles after the sample.
- `reset` is pulsed during the 2nd RD cycle → `memRead` drops within the cycle and no done is produced. A following tie is won by port 0, and the reissued read completes normally.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake and memory-side strobe/data bundle for dmem_arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              done0, done1;
    logic              err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memDataIn;
    logic [DATA_W-1:0] memDataOut;
    logic              memRead, memWrite;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memDataOut,
        output done0, done1, err0, err1, rdata0, rdata1,
               memAddr, memDataIn, memRead, memWrite, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memDataOut,
        input  done0, done1, err0, err1, rdata0, rdata1,
               memAddr, memDataIn, memRead, memWrite, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer for a byte-addressed, big-endian word memory.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    // Highest address whose four bytes still fit inside the memory.
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'((1 << ADDR_W) - 4);
    localparam logic [1:0]        CNT_INIT = 2'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic              id_q, last_id_q, err_q;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q, rdata0_q, rdata1_q;

    logic              grant, grant_id, sel_we, addr_err, capture;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        grant_id  = id_q;
        capture   = 1'b0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        addr_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant     = 1'b1;
                    // On a tie the port that was not served last takes the grant.
                    grant_id  = (bus.req0 && bus.req1) ? ~last_id_q : bus.req1;
                    sel_we    = grant_id ? bus.we1    : bus.we0;
                    sel_addr  = grant_id ? bus.addr1  : bus.addr0;
                    sel_wdata = grant_id ? bus.wdata1 : bus.wdata0;
                    addr_err  = (sel_addr > MAX_ADDR);
                    if (addr_err) begin
                        state_d = S_DONE;
                    end else if (sel_we) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WR: state_d = S_DONE;
            S_RD: begin
                if (cnt_q == 2'd0) begin
                    capture = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_q       <= 1'b0;
            last_id_q  <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= 2'd0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (grant) begin
                id_q      <= grant_id;
                last_id_q <= grant_id;
                err_q     <= addr_err;
                // Rejected accesses leave the memory-side registers untouched.
                if (!addr_err) begin
                    mem_addr_q <= sel_addr;
                    if (sel_we) mem_din_q <= sel_wdata;
                end
            end
            if (capture) begin
                if (id_q) rdata1_q <= bus.memDataOut;
                else      rdata0_q <= bus.memDataOut;
            end
        end
    end

    assign bus.memRead   = (state_q == S_RD);
    assign bus.memWrite  = (state_q == S_WR);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done0     = (state_q == S_DONE) && !id_q;
    assign bus.done1     = (state_q == S_DONE) &&  id_q;
    assign bus.err0      = bus.done0 && err_q;
    assign bus.err1      = bus.done1 && err_q;
    assign bus.memAddr   = mem_addr_q;
    assign bus.memDataIn = mem_din_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (RD_LAT 1 and 3), each with a byte memory, checked against a transaction-level model.
module tb_dmem_arbiter;
    localparam int AW   = 6;
    localparam int DW   = 32;
    localparam int MAXA = (1 << AW) - 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]    req0_d = '0, req1_d = '0, we0_d = '0, we1_d = '0;
    logic [AW-1:0] addr0_d [2];
    logic [AW-1:0] addr1_d [2];
    logic [DW-1:0] wdata0_d [2];
    logic [DW-1:0] wdata1_d [2];

    logic [1:0]    done0_o, done1_o, err0_o, err1_o, rd_o, wr_o, busy_o;
    logic [DW-1:0] rdata0_o [2];
    logic [DW-1:0] rdata1_o [2];
    logic [DW-1:0] mdin_o [2];
    logic [AW-1:0] maddr_o [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]    ref_mem [2][64];
    bit            ref_last [2];
    logic [DW-1:0] ref_rd0 [2];
    logic [DW-1:0] ref_rd1 [2];

    int            exp_port, exp_k, exp_rd, exp_wr;
    bit            exp_err, exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata, exp_rdata;

    int            obs_port, obs_k, obs_rd, obs_wr;
    bit            obs_err, obs_both;
    logic [AW-1:0] obs_maddr;
    logic [DW-1:0] obs_mdin, obs_rdata;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [7:0] mem [64];

        dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );

        assign bus.req0   = req0_d[g];
        assign bus.req1   = req1_d[g];
        assign bus.we0    = we0_d[g];
        assign bus.we1    = we1_d[g];
        assign bus.addr0  = addr0_d[g];
        assign bus.addr1  = addr1_d[g];
        assign bus.wdata0 = wdata0_d[g];
        assign bus.wdata1 = wdata1_d[g];
        assign bus.memDataOut = {mem[bus.memAddr], mem[bus.memAddr + 6'd1],
                                 mem[bus.memAddr + 6'd2], mem[bus.memAddr + 6'd3]};

        initial for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
        always @(posedge clk) begin
            if (bus.memWrite) begin
                mem[bus.memAddr]        <= bus.memDataIn[31:24];
                mem[bus.memAddr + 6'd1] <= bus.memDataIn[23:16];
                mem[bus.memAddr + 6'd2] <= bus.memDataIn[15:8];
                mem[bus.memAddr + 6'd3] <= bus.memDataIn[7:0];
            end
        end

        assign done0_o[g]  = bus.done0;
        assign done1_o[g]  = bus.done1;
        assign err0_o[g]   = bus.err0;
        assign err1_o[g]   = bus.err1;
        assign rd_o[g]     = bus.memRead;
        assign wr_o[g]     = bus.memWrite;
        assign busy_o[g]   = bus.busy;
        assign rdata0_o[g] = bus.rdata0;
        assign rdata1_o[g] = bus.rdata1;
        assign mdin_o[g]   = bus.memDataIn;
        assign maddr_o[g]  = bus.memAddr;
    end

    function automatic int lat_of(input int inst);
        return (inst == 0) ? 1 : 3;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 6'($urandom_range(61, 63));
        return 6'($urandom_range(0, 60));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ref_last[i] = 1'b1;
            ref_rd0[i]  = '0;
            ref_rd1[i]  = '0;
        end
    endtask

    // Predict the next grant from the pending requests and advance the model.
    task automatic model_step(input int inst);
        bit p;
        int a;
        p = (req0_d[inst] && req1_d[inst]) ? !ref_last[inst] : req1_d[inst];
        exp_port  = p ? 1 : 0;
        exp_we    = p ? we1_d[inst] : we0_d[inst];
        exp_addr  = p ? addr1_d[inst] : addr0_d[inst];
        exp_wdata = p ? wdata1_d[inst] : wdata0_d[inst];
        a         = int'(exp_addr);
        exp_err   = (a > MAXA);
        exp_k     = exp_err ? 0 : (exp_we ? 1 : lat_of(inst));
        exp_rd    = (!exp_err && !exp_we) ? lat_of(inst) : 0;
        exp_wr    = (!exp_err && exp_we) ? 1 : 0;
        ref_last[inst] = p;
        if (!exp_err && exp_we)
            for (int b = 0; b < 4; b++) ref_mem[inst][a + b] = exp_wdata[31 - 8 * b -: 8];
        if (!exp_err && !exp_we) begin
            exp_rdata = {ref_mem[inst][a], ref_mem[inst][a + 1], ref_mem[inst][a + 2], ref_mem[inst][a + 3]};
            if (p) ref_rd1[inst] = exp_rdata;
            else   ref_rd0[inst] = exp_rdata;
        end else begin
            exp_rdata = p ? ref_rd1[inst] : ref_rd0[inst];
        end
    endtask

    // Run one grant to completion, recording what the DUT did, then retire the served req.
    task automatic serve(input int inst);
        obs_port = -1; obs_k = -1; obs_rd = 0; obs_wr = 0;
        obs_err = 1'b0; obs_both = 1'b0;
        obs_maddr = '0; obs_mdin = '0; obs_rdata = '0;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rd_o[inst] && wr_o[inst]) obs_both = 1'b1;
            if (rd_o[inst]) begin obs_rd++; obs_maddr = maddr_o[inst]; end
            if (wr_o[inst]) begin obs_wr++; obs_maddr = maddr_o[inst]; obs_mdin = mdin_o[inst]; end
            if (done0_o[inst] || done1_o[inst]) begin
                obs_port  = (done0_o[inst] && done1_o[inst]) ? 2 : (done1_o[inst] ? 1 : 0);
                obs_k     = k;
                obs_err   = done1_o[inst] ? err1_o[inst] : err0_o[inst];
                obs_rdata = done1_o[inst] ? rdata1_o[inst] : rdata0_o[inst];
                break;
            end
        end
        @(posedge clk);
        #1;
        if (obs_port == 0)      req0_d[inst] = 1'b0;
        else if (obs_port == 1) req1_d[inst] = 1'b0;
        else begin req0_d[inst] = 1'b0; req1_d[inst] = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({done0_o[i], done1_o[i], err0_o[i], err1_o[i], rd_o[i], wr_o[i], busy_o[i]} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got %b want 0000000", i,
                         {done0_o[i], done1_o[i], err0_o[i], err1_o[i], rd_o[i], wr_o[i], busy_o[i]});
            end
            n_tests++;
            if ({rdata0_o[i], rdata1_o[i]} !== 64'h0) begin
                n_fail++; $display("FAIL reset_rdata[%0d]: got %h/%h want 0", i, rdata0_o[i], rdata1_o[i]);
            end
            n_tests++;
            if ({maddr_o[i], mdin_o[i]} !== 38'h0) begin
                n_fail++; $display("FAIL reset_memside[%0d]: got %h/%h want 0", i, maddr_o[i], mdin_o[i]);
            end
        end
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_tie();
        for (int r = 0; r < 2; r++) begin
            req0_d[0] = 1'b1; we0_d[0] = 1'b0; addr0_d[0] = 6'(4 * r);
            req1_d[0] = 1'b1; we1_d[0] = 1'b0; addr1_d[0] = 6'(20 + 4 * r);
            for (int j = 0; j < 2; j++) begin
                model_step(0);
                serve(0);
                n_tests++;
                if (obs_port != j) begin
                    n_fail++; $display("FAIL tie_order[%0d]: got port %0d want %0d", 2 * r + j, obs_port, j);
                end
                n_tests++;
                if (obs_k != 1 || obs_rd != 1) begin
                    n_fail++; $display("FAIL tie_timing[%0d]: got k=%0d rd=%0d want 1/1", 2 * r + j, obs_k, obs_rd);
                end
            end
        end
    endtask

    task automatic test_write();
        req0_d[0] = 1'b1; we0_d[0] = 1'b1; addr0_d[0] = 6'd8; wdata0_d[0] = 32'hDEADBEEF;
        model_step(0);
        serve(0);
        n_tests++;
        if (obs_wr != 1 || obs_rd != 0) begin
            n_fail++; $display("FAIL write_strobe: got wr=%0d rd=%0d want 1/0", obs_wr, obs_rd);
        end
        n_tests++;
        if (obs_maddr !== 6'd8 || obs_mdin !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL write_bus: got %0d/%h want 8/deadbeef", obs_maddr, obs_mdin);
        end
        n_tests++;
        if (obs_port != 0 || obs_k != 1 || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL write_done: got port=%0d k=%0d err=%0b want 0/1/0", obs_port, obs_k, obs_err);
        end
    endtask

    task automatic test_read();
        req1_d[0] = 1'b1; we1_d[0] = 1'b0; addr1_d[0] = 6'd8;
        model_step(0);
        serve(0);
        n_tests++;
        if (obs_port != 1 || obs_k != 1 || obs_rd != 1) begin
            n_fail++; $display("FAIL read_done: got port=%0d k=%0d rd=%0d want 1/1/1", obs_port, obs_k, obs_rd);
        end
        n_tests++;
        if (obs_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_data: got %h want deadbeef", obs_rdata);
        end
        n_tests++;
        if (rdata1_o[0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_hold: got %h want deadbeef", rdata1_o[0]);
        end
    endtask

    task automatic test_range();
        req0_d[0] = 1'b1; we0_d[0] = 1'b1; addr0_d[0] = 6'd63; wdata0_d[0] = 32'hFFFF0000;
        model_step(0);
        serve(0);
        n_tests++;
        if (obs_err !== 1'b1 || obs_k != 0 || obs_wr != 0) begin
            n_fail++; $display("FAIL range_wr63: got err=%0b k=%0d wr=%0d want 1/0/0", obs_err, obs_k, obs_wr);
        end
        req0_d[0] = 1'b1; we0_d[0] = 1'b1; addr0_d[0] = 6'd60; wdata0_d[0] = 32'h01234567;
        model_step(0);
        serve(0);
        req0_d[0] = 1'b1; we0_d[0] = 1'b0; addr0_d[0] = 6'd61;
        model_step(0);
        serve(0);
        n_tests++;
        if (obs_port != 0 || obs_err !== 1'b1 || obs_k != 0 || obs_rd != 0) begin
            n_fail++; $display("FAIL range_rd61: got port=%0d err=%0b k=%0d rd=%0d want 0/1/0/0", obs_port, obs_err, obs_k, obs_rd);
        end
        n_tests++;
        if (rdata0_o[0] !== ref_rd0[0]) begin
            n_fail++; $display("FAIL range_rdata_kept: got %h want %h", rdata0_o[0], ref_rd0[0]);
        end
        req0_d[0] = 1'b1; we0_d[0] = 1'b0; addr0_d[0] = 6'd60;
        model_step(0);
        serve(0);
        n_tests++;
        if (obs_err !== 1'b0 || obs_k != 1 || obs_rdata !== 32'h01234567) begin
            n_fail++; $display("FAIL range_rd60: got err=%0b k=%0d data=%h want 0/1/01234567", obs_err, obs_k, obs_rdata);
        end
    endtask

    task automatic test_latency();
        req0_d[1] = 1'b1; we0_d[1] = 1'b1; addr0_d[1] = 6'd4; wdata0_d[1] = $urandom();
        model_step(1);
        serve(1);
        req0_d[1] = 1'b1; we0_d[1] = 1'b0; addr0_d[1] = 6'd4;
        model_step(1);
        serve(1);
        n_tests++;
        if (obs_rd != 3 || obs_k != 3) begin
            n_fail++; $display("FAIL lat3_timing: got rd=%0d k=%0d want 3/3", obs_rd, obs_k);
        end
        n_tests++;
        if (obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL lat3_data: got %h want %h", obs_rdata, exp_rdata);
        end
    endtask

    task automatic test_reset_abort();
        bit seen;
        req0_d[1] = 1'b1; we0_d[1] = 1'b0; addr0_d[1] = 6'd4;
        @(posedge clk);
        @(posedge clk);
        #2;
        n_tests++;
        if (rd_o[1] !== 1'b1) begin
            n_fail++; $display("FAIL abort_pre_rd: got %b want 1", rd_o[1]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({rd_o[1], busy_o[1], done0_o[1], done1_o[1]} !== 4'b0) begin
            n_fail++; $display("FAIL abort_drop: got rd/busy/done %b want 0000", {rd_o[1], busy_o[1], done0_o[1], done1_o[1]});
        end
        req0_d[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        n_tests++;
        if (rdata0_o[1] !== '0) begin
            n_fail++; $display("FAIL abort_rdata_clr: got %h want 0", rdata0_o[1]);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (done0_o[1] || done1_o[1]) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL abort_no_done: got a done pulse want none");
        end
        @(posedge clk);
        #1;
        req0_d[1] = 1'b1; we0_d[1] = 1'b0; addr0_d[1] = 6'd4;
        req1_d[1] = 1'b1; we1_d[1] = 1'b0; addr1_d[1] = 6'd8;
        model_step(1);
        serve(1);
        n_tests++;
        if (obs_port != 0 || obs_k != 3 || obs_rdata !== exp_rdata) begin
            n_fail++; $display("FAIL abort_reissue: got port=%0d k=%0d data=%h want 0/3/%h", obs_port, obs_k, obs_rdata, exp_rdata);
        end
        model_step(1);
        serve(1);
        n_tests++;
        if (obs_port != 1) begin
            n_fail++; $display("FAIL abort_second: got port %0d want 1", obs_port);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            int inst, mask, n;
            inst = int'($urandom_range(0, 1));
            mask = int'($urandom_range(1, 3));
            if (mask[0]) begin
                req0_d[inst] = 1'b1; we0_d[inst] = 1'($urandom_range(0, 1));
                addr0_d[inst] = rand_addr(); wdata0_d[inst] = $urandom();
            end
            if (mask[1]) begin
                req1_d[inst] = 1'b1; we1_d[inst] = 1'($urandom_range(0, 1));
                addr1_d[inst] = rand_addr(); wdata1_d[inst] = $urandom();
            end
            n = (mask == 3) ? 2 : 1;
            for (int j = 0; j < n; j++) begin
                model_step(inst);
                serve(inst);
                n_tests++;
                if (obs_port != exp_port || obs_k != exp_k || obs_err !== exp_err) begin
                    n_fail++;
                    $display("FAIL rnd_done[%0d]: got port=%0d k=%0d err=%0b want %0d/%0d/%0b",
                             it, obs_port, obs_k, obs_err, exp_port, exp_k, exp_err);
                end
                n_tests++;
                if (obs_rd != exp_rd || obs_wr != exp_wr || obs_both) begin
                    n_fail++;
                    $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d both=%0b want %0d/%0d/0",
                             it, obs_rd, obs_wr, obs_both, exp_rd, exp_wr);
                end
                if (exp_rd + exp_wr > 0) begin
                    n_tests++;
                    if (obs_maddr !== exp_addr || (exp_wr == 1 && obs_mdin !== exp_wdata)) begin
                        n_fail++;
                        $display("FAIL rnd_membus[%0d]: got %0d/%h want %0d/%h", it, obs_maddr, obs_mdin, exp_addr, exp_wdata);
                    end
                end
                n_tests++;
                if (obs_rdata !== exp_rdata || rdata0_o[inst] !== ref_rd0[inst] || rdata1_o[inst] !== ref_rd1[inst]) begin
                    n_fail++;
                    $display("FAIL rnd_rdata[%0d]: got %h (%h/%h) want %h (%h/%h)", it, obs_rdata,
                             rdata0_o[inst], rdata1_o[inst], exp_rdata, ref_rd0[inst], ref_rd1[inst]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            addr0_d[i] = '0; addr1_d[i] = '0; wdata0_d[i] = '0; wdata1_d[i] = '0;
            for (int a = 0; a < 64; a++) ref_mem[i][a] = 8'h00;
        end
        model_reset();
        test_reset();
        test_tie();
        test_write();
        test_read();
        test_range();
        test_latency();
        test_reset_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
